sb_access_ctrl: RTL and testbench

SB_ACCESS_CTRL -- requirements
Module: sb_access_ctrl

---
 rtl/sb_access_ctrl_if.sv | 31 +++
 rtl/sb_access_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sb_access_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sb_access_ctrl_if.sv
// DMI register-access strobe and system-bus request/response bundle for sb_access_ctrl.
// The slave modport is the controller's view; master is the view of whoever drives it.
interface sb_access_ctrl_if;
    logic [6:0]  dmi_address;
    logic [31:0] dmi_wdata;
    logic        dmi_write;
    logic        dmi_read;
    logic [31:0] dmi_rdata;

    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport slave (
        input  dmi_address, dmi_wdata, dmi_write, dmi_read,
        output dmi_rdata,
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_ack, bus_err, bus_rdata
    );

    modport master (
        output dmi_address, dmi_wdata, dmi_write, dmi_read,
        input  dmi_rdata,
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/sb_access_ctrl.sv
// Debug-module system-bus access controller: sbcs/sbaddress0/sbdata0 registers driving
// single 32-bit bus reads/writes with busy, error and timeout tracking.
//   state | meaning
//   IDLE  | no bus access outstanding, sbbusy=0
//   RD    | bus read outstanding, waiting for ack/err/timeout
//   WR    | bus write outstanding, waiting for ack/err/timeout
module sb_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            dmactive,
    sb_access_ctrl_if.slave sb_if
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [6:0]  LP_ADDR_SBCS  = 7'h38;
    localparam logic [6:0]  LP_ADDR_SBADR = 7'h39;
    localparam logic [6:0]  LP_ADDR_SBDAT = 7'h3C;
    localparam logic [15:0] LP_TIMEOUT    = 16'(TIMEOUT);

    state_t      r_state;
    logic [31:0] r_sbaddress0;
    logic [31:0] r_sbdata0;
    logic        r_sbbusyerror;
    logic        r_sbreadonaddr;
    logic [2:0]  r_sbaccess;
    logic        r_sbautoincrement;
    logic        r_sbreadondata;
    logic [2:0]  r_sberror;
    logic [15:0] r_cnt;

    state_t      w_state_nxt;
    logic [31:0] w_addr_nxt;
    logic [31:0] w_data_nxt;
    logic        w_busyerr_nxt;
    logic        w_readonaddr_nxt;
    logic [2:0]  w_access_nxt;
    logic        w_autoinc_nxt;
    logic        w_readondata_nxt;
    logic [2:0]  w_err_base;
    logic [2:0]  w_err_clr;
    logic [2:0]  w_sberror_nxt;
    logic [15:0] w_cnt_nxt;
    logic [15:0] w_cnt_inc;
    logic        w_start;
    logic        w_start_we;
    logic        w_busy;
    logic        w_err_any;
    logic        w_wr;
    logic        w_rd;
    logic [31:0] w_sbcs;

    assign w_busy    = (r_state != IDLE);
    assign w_err_any = r_sbbusyerror | (r_sberror != 3'd0);
    assign w_wr      = sb_if.dmi_write;
    assign w_rd      = sb_if.dmi_read & ~sb_if.dmi_write;
    assign w_cnt_inc = r_cnt + 16'd1;

    assign w_sbcs = {3'b001, 6'b0, r_sbbusyerror, w_busy, r_sbreadonaddr, r_sbaccess,
                     r_sbautoincrement, r_sbreadondata, r_sberror, 7'd32, 2'b00, 1'b1, 2'b00};

    always_comb begin
        case (sb_if.dmi_address)
            LP_ADDR_SBCS:  sb_if.dmi_rdata = w_sbcs;
            LP_ADDR_SBADR: sb_if.dmi_rdata = r_sbaddress0;
            LP_ADDR_SBDAT: sb_if.dmi_rdata = r_sbdata0;
            default:       sb_if.dmi_rdata = 32'd0;
        endcase
    end

    assign sb_if.bus_req   = w_busy;
    assign sb_if.bus_we    = (r_state == WR);
    assign sb_if.bus_addr  = r_sbaddress0;
    assign sb_if.bus_wdata = r_sbdata0;

    always_comb begin
        w_state_nxt      = r_state;
        w_addr_nxt       = r_sbaddress0;
        w_data_nxt       = r_sbdata0;
        w_busyerr_nxt    = r_sbbusyerror;
        w_readonaddr_nxt = r_sbreadonaddr;
        w_access_nxt     = r_sbaccess;
        w_autoinc_nxt    = r_sbautoincrement;
        w_readondata_nxt = r_sbreadondata;
        w_err_base       = r_sberror;
        w_err_clr        = 3'd0;
        w_cnt_nxt        = r_cnt;
        w_start          = 1'b0;
        w_start_we       = 1'b0;

        case (r_state)
            RD, WR: begin
                if (sb_if.bus_err) begin
                    w_err_base  = 3'd7;
                    w_state_nxt = IDLE;
                end else if (sb_if.bus_ack) begin
                    if (r_state == RD)
                        w_data_nxt = sb_if.bus_rdata;
                    if (r_sbautoincrement)
                        w_addr_nxt = r_sbaddress0 + 32'd4;
                    w_state_nxt = IDLE;
                end else if (w_cnt_inc == LP_TIMEOUT) begin
                    w_err_base  = 3'd1;
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: ;
        endcase

        // Busy-time DMI accesses never touch address/data, so they cannot collide with completion.
        if (w_wr && sb_if.dmi_address == LP_ADDR_SBCS) begin
            w_readonaddr_nxt = sb_if.dmi_wdata[20];
            w_access_nxt     = sb_if.dmi_wdata[19:17];
            w_autoinc_nxt    = sb_if.dmi_wdata[16];
            w_readondata_nxt = sb_if.dmi_wdata[15];
            w_err_clr        = sb_if.dmi_wdata[14:12];
            if (sb_if.dmi_wdata[22])
                w_busyerr_nxt = 1'b0;
        end else if (w_wr && sb_if.dmi_address == LP_ADDR_SBADR) begin
            if (w_busy) begin
                w_busyerr_nxt = 1'b1;
            end else begin
                w_addr_nxt = sb_if.dmi_wdata;
                w_start    = ~w_err_any & r_sbreadonaddr;
            end
        end else if (w_wr && sb_if.dmi_address == LP_ADDR_SBDAT) begin
            if (w_busy) begin
                w_busyerr_nxt = 1'b1;
            end else if (!w_err_any) begin
                w_data_nxt = sb_if.dmi_wdata;
                w_start    = 1'b1;
                w_start_we = 1'b1;
            end
        end else if (w_rd && sb_if.dmi_address == LP_ADDR_SBDAT) begin
            if (w_busy)
                w_busyerr_nxt = 1'b1;
            else
                w_start = ~w_err_any & r_sbreadondata;
        end

        if (w_start) begin
            if (r_sbaccess != 3'd2) begin
                w_err_base = 3'd4;
            end else begin
                w_state_nxt = w_start_we ? WR : RD;
                w_cnt_nxt   = 16'd0;
            end
        end

        w_sberror_nxt = w_err_base & ~w_err_clr;
    end

    always_ff @(posedge clk) begin
        if (rst || !dmactive) begin
            r_state           <= IDLE;
            r_sbaddress0      <= 32'd0;
            r_sbdata0         <= 32'd0;
            r_sbbusyerror     <= 1'b0;
            r_sbreadonaddr    <= 1'b0;
            r_sbaccess        <= 3'd2;
            r_sbautoincrement <= 1'b0;
            r_sbreadondata    <= 1'b0;
            r_sberror         <= 3'd0;
            r_cnt             <= 16'd0;
        end else begin
            r_state           <= w_state_nxt;
            r_sbaddress0      <= w_addr_nxt;
            r_sbdata0         <= w_data_nxt;
            r_sbbusyerror     <= w_busyerr_nxt;
            r_sbreadonaddr    <= w_readonaddr_nxt;
            r_sbaccess        <= w_access_nxt;
            r_sbautoincrement <= w_autoinc_nxt;
            r_sbreadondata    <= w_readondata_nxt;
            r_sberror         <= w_sberror_nxt;
            r_cnt             <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_sb_access_ctrl.sv
// Bench for sb_access_ctrl: directed register scenarios, then random DMI/bus traffic,
// every cycle compared against a transaction-level model of the register rules.
module tb_sb_access_ctrl;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dmactive = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int n_bus_cycles = 0;
    logic prev_req = 1'b0;

    // model state
    logic [31:0] m_addr, m_data;
    logic        m_busy, m_we, m_busyerr, m_readonaddr, m_autoinc, m_readondata;
    logic [2:0]  m_access, m_err;
    int          m_wait;

    sb_access_ctrl_if u_if();

    sb_access_ctrl #(.TIMEOUT(TMO)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .dmactive (dmactive),
        .sb_if    (u_if)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_data = 0; m_busy = 0; m_we = 0; m_busyerr = 0;
        m_readonaddr = 0; m_autoinc = 0; m_readondata = 0;
        m_access = 3'd2; m_err = 0; m_wait = 0;
    endtask

    function automatic logic [31:0] model_rdata(input logic [6:0] a);
        logic [31:0] v;
        case (a)
            7'h38: begin
                v = 32'h2000_0000 + (32'd32 << 5) + 32'd4;
                v += 32'(m_busyerr) << 22;
                v += 32'(m_busy) << 21;
                v += 32'(m_readonaddr) << 20;
                v += 32'(m_access) << 17;
                v += 32'(m_autoinc) << 16;
                v += 32'(m_readondata) << 15;
                v += 32'(m_err) << 12;
            end
            7'h39:   v = m_addr;
            7'h3C:   v = m_data;
            default: v = 0;
        endcase
        return v;
    endfunction

    task automatic model_edge();
        logic was_busy, clean, wr, rd, start, start_we;
        logic [2:0] err_v, clr;
        if (rst || !dmactive) begin
            model_reset();
            return;
        end
        was_busy = m_busy;
        clean    = !m_busyerr && (m_err == 0);
        err_v    = m_err;
        clr      = 0;
        start    = 0;
        start_we = 0;
        wr = u_if.dmi_write;
        rd = u_if.dmi_read && !u_if.dmi_write;
        if (was_busy) begin
            m_wait++;
            if (u_if.bus_err) begin
                err_v = 7; m_busy = 0;
            end else if (u_if.bus_ack) begin
                if (!m_we) m_data = u_if.bus_rdata;
                if (m_autoinc) m_addr = m_addr + 4;
                m_busy = 0;
            end else if (m_wait >= TMO) begin
                err_v = 1; m_busy = 0;
            end
        end
        if (wr && u_if.dmi_address == 7'h38) begin
            m_readonaddr = u_if.dmi_wdata[20];
            m_access     = u_if.dmi_wdata[19:17];
            m_autoinc    = u_if.dmi_wdata[16];
            m_readondata = u_if.dmi_wdata[15];
            clr          = u_if.dmi_wdata[14:12];
            if (u_if.dmi_wdata[22]) m_busyerr = 0;
        end else if (wr && u_if.dmi_address == 7'h39) begin
            if (was_busy) m_busyerr = 1;
            else begin
                m_addr = u_if.dmi_wdata;
                start  = clean && m_readonaddr;
            end
        end else if (wr && u_if.dmi_address == 7'h3C) begin
            if (was_busy) m_busyerr = 1;
            else if (clean) begin
                m_data = u_if.dmi_wdata; start = 1; start_we = 1;
            end
        end else if (rd && u_if.dmi_address == 7'h3C) begin
            if (was_busy) m_busyerr = 1;
            else start = clean && m_readondata;
        end
        if (start) begin
            if (m_access != 3'd2) err_v = 4;
            else begin
                m_busy = 1; m_we = start_we; m_wait = 0;
            end
        end
        m_err = err_v & ~clr;
    endtask

    task automatic set_in(input logic w, input logic r, input logic [6:0] a, input logic [31:0] d,
                          input logic ack, input logic err, input logic [31:0] brd);
        u_if.dmi_write   = w;
        u_if.dmi_read    = r;
        u_if.dmi_address = a;
        u_if.dmi_wdata   = d;
        u_if.bus_ack     = ack;
        u_if.bus_err     = err;
        u_if.bus_rdata   = brd;
    endtask

    task automatic set_idle();
        set_in(0, 0, 7'h00, 32'd0, 0, 0, 32'd0);
    endtask

    // Compare against the model, advance one clock, update the model, return at negedge.
    task automatic tick();
        #1;
        check_val("dmi_rdata", u_if.dmi_rdata, model_rdata(u_if.dmi_address));
        check_val("bus_req", 32'(u_if.bus_req), 32'(m_busy));
        if (m_busy) begin
            check_val("bus_we", 32'(u_if.bus_we), 32'(m_we));
            check_val("bus_addr", u_if.bus_addr, m_addr);
            check_val("bus_wdata", u_if.bus_wdata, m_data);
        end
        if (u_if.bus_req && !prev_req) n_bus_cycles++;
        prev_req = u_if.bus_req;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        set_idle();
    endtask

    task automatic dmi_write(input logic [6:0] a, input logic [31:0] d);
        set_in(1, 0, a, d, 0, 0, 32'd0);
        tick();
    endtask

    task automatic read_expect(input string tag, input logic [6:0] a, input logic [31:0] exp);
        set_in(0, 1, a, 32'd0, 0, 0, 32'd0);
        #1;
        check_val(tag, u_if.dmi_rdata, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_hi;
        model_reset();
        set_idle();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;

        read_expect("reset_sbcs", 7'h38, 32'h2004_0404);
        read_expect("reset_addr", 7'h39, 32'h0);
        read_expect("reset_data", 7'h3C, 32'h0);
        read_expect("other_addr", 7'h10, 32'h0);

        // write with autoincrement
        dmi_write(7'h38, 32'h0005_0000);
        dmi_write(7'h39, 32'h0000_1000);
        dmi_write(7'h3C, 32'hDEAD_BEEF);
        #1;
        check_val("wr_req", 32'(u_if.bus_req), 32'd1);
        check_val("wr_we", 32'(u_if.bus_we), 32'd1);
        check_val("wr_addr", u_if.bus_addr, 32'h0000_1000);
        check_val("wr_wdata", u_if.bus_wdata, 32'hDEAD_BEEF);
        tick();
        tick();
        set_in(0, 0, 7'h00, 32'd0, 1, 0, 32'd0);
        tick();
        read_expect("wr_autoinc", 7'h39, 32'h0000_1004);
        set_in(0, 1, 7'h38, 32'd0, 0, 0, 32'd0);
        #1;
        check_val("wr_sbbusy", 32'(u_if.dmi_rdata[21]), 32'd0);
        tick();

        // read on address
        dmi_write(7'h38, 32'h0014_0000);
        dmi_write(7'h39, 32'h0000_0020);
        #1;
        check_val("rd_we", 32'(u_if.bus_we), 32'd0);
        set_in(0, 0, 7'h00, 32'd0, 1, 0, 32'h1234_5678);
        tick();
        read_expect("rd_data", 7'h3C, 32'h1234_5678);
        read_expect("rd_addr", 7'h39, 32'h0000_0020);

        // busy error: second sbdata0 write while ack withheld
        dmi_write(7'h38, 32'h0004_0000);
        n_bus_cycles = 0;
        dmi_write(7'h3C, 32'hAAAA_0001);
        dmi_write(7'h3C, 32'hBBBB_0002);
        set_in(0, 0, 7'h00, 32'd0, 1, 0, 32'd0);
        tick();
        tick();
        check_val("busy_cycles", 32'(n_bus_cycles), 32'd1);
        set_in(0, 1, 7'h38, 32'd0, 0, 0, 32'd0);
        #1;
        check_val("busyerr_set", 32'(u_if.dmi_rdata[22]), 32'd1);
        tick();
        read_expect("busy_data", 7'h3C, 32'hAAAA_0001);
        dmi_write(7'h38, 32'h0044_0000);
        set_in(0, 1, 7'h38, 32'd0, 0, 0, 32'd0);
        #1;
        check_val("busyerr_clr", 32'(u_if.dmi_rdata[22]), 32'd0);
        tick();

        // timeout
        dmi_write(7'h3C, 32'h0000_5555);
        n_hi = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (u_if.bus_req) n_hi++;
            tick();
        end
        check_val("tmo_cycles", 32'(n_hi), 32'd4);
        set_in(0, 1, 7'h38, 32'd0, 0, 0, 32'd0);
        #1;
        check_val("tmo_sberror", 32'(u_if.dmi_rdata[14:12]), 32'd1);
        tick();
        dmi_write(7'h3C, 32'h0000_6666);
        #1;
        check_val("tmo_no_req", 32'(u_if.bus_req), 32'd0);
        tick();
        dmi_write(7'h38, 32'h0004_7000);

        // unsupported size
        dmi_write(7'h38, 32'h0002_0000);
        dmi_write(7'h3C, 32'h0000_7777);
        #1;
        check_val("size_no_req", 32'(u_if.bus_req), 32'd0);
        tick();
        set_in(0, 1, 7'h38, 32'd0, 0, 0, 32'd0);
        #1;
        check_val("size_sberror", 32'(u_if.dmi_rdata[14:12]), 32'd4);
        tick();
        dmi_write(7'h38, 32'h0014_7000);

        // reset mid-read
        dmi_write(7'h39, 32'h0000_0040);
        #1;
        check_val("rst_req_before", 32'(u_if.bus_req), 32'd1);
        rst = 1;
        tick();
        rst = 0;
        #1;
        check_val("rst_req_after", 32'(u_if.bus_req), 32'd0);
        read_expect("rst_sbcs", 7'h38, 32'h2004_0404);

        // random traffic against the model
        for (int c = 0; c < 4000; c++) begin
            logic [6:0]  a;
            logic [31:0] d;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1:    a = 7'h38;
                2, 3:    a = 7'h39;
                4, 5, 6: a = 7'h3C;
                default: a = 7'($urandom_range(0, 127));
            endcase
            d = $urandom;
            if (a == 7'h38 && $urandom_range(0, 9) < 8) d[19:17] = 3'd2;
            set_in($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, a, d,
                   $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5, $urandom);
            rst      = ($urandom_range(0, 199) == 0);
            dmactive = ($urandom_range(0, 199) != 0);
            tick();
        end
        rst = 0;
        dmactive = 1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
